fc_layer2: RTL and testbench

Fully-connected stage directly downstream of the 5x5 convolution / max-pool engine. After that engine finishes and drops `busy`, this block:
- reads the 32x32 layer-1 feature map (13-bit, 9.4 unsigned) from the shared result memory, bank `csel=1`;
- multiplies every pixel against N_OUT signed weight vectors and adds per-neuron biases;
- applies ReLU and saturation, then writes N_OUT 13-bit results to the output memory.

All N_OUT neurons accumulate in parallel, so the feature map is read exactly once.

---
 rtl/fc_layer2_pkg.sv | 9 +
 rtl/fc_mac_lane.sv | 51 +++++
 rtl/fc_layer2.sv | 143 ++++++++++++++
 tb/tb_fc_layer2.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer2_pkg.sv
// Shared fixed-point constants and bank-select encodings
// used by the convolution engine and the fully-connected stage.
package fc_layer2_pkg;
  localparam int FRAC_W = 4;
  localparam int DATA_W = 13;
  localparam logic [DATA_W-1:0] MAX13 = 13'h1FFF;
  localparam logic CSEL_L0 = 1'b0;
  localparam logic CSEL_L1 = 1'b1;
endpackage

// File: rtl/fc_mac_lane.sv
// One neuron: ACC_W accumulator with bias load, clear and MAC.
// Ports: clk/reset, clr_i, load_i, acc_en_i, pix_i, wgt_i, bias_i; res_o = ReLU/sat result.
module fc_mac_lane
  import fc_layer2_pkg::*;
#(
  parameter int ACC_W = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              acc_en_i,
  input  logic [DATA_W-1:0] pix_i,
  input  logic [DATA_W-1:0] wgt_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] res_o
);
  localparam int PW = 2 * DATA_W + 1;
  localparam int HI = DATA_W + FRAC_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod;

  // Pixel is unsigned, so it gets a zero MSB before the signed multiply.
  assign prod = $signed({1'b0, pix_i}) * $signed(wgt_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (load_i)
      acc_d = {{(ACC_W-DATA_W-FRAC_W){bias_i[DATA_W-1]}},
               bias_i, {FRAC_W{1'b0}}};
    else if (acc_en_i)
      acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  always_comb begin
    if (acc_q[ACC_W-1])
      res_o = '0;
    else if (|acc_q[ACC_W-2:HI])
      res_o = MAX13;
    else
      res_o = acc_q[HI-1:FRAC_W];
  end
endmodule

// File: rtl/fc_layer2.sv
// Fully-connected layer 2: one pass over layer-1 map, N_OUT parallel MACs.
// Ports: start/busy/done handshake, layer-1 read (crd/csel/caddr_rd/cdata_rd), weights, bias, output write.
module fc_layer2
  import fc_layer2_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int N_PIX = 1024,
  parameter int ACC_W = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  crd,
  output logic                  csel,
  output logic [11:0]           caddr_rd,
  input  logic [12:0]           cdata_rd,
  output logic [9:0]            waddr,
  input  logic [13*N_OUT-1:0]   wdata,
  input  logic [13*N_OUT-1:0]   bias,
  output logic                  owr,
  output logic [11:0]           oaddr,
  output logic [12:0]           odata
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [11:0]   LAST_A = 12'(N_PIX - 1);
  localparam logic [CW-1:0] LAST_K = CW'(N_OUT - 1);

  logic [2:0]        state_q, state_d;
  logic [11:0]       addr_q, addr_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              crd_q, crd_d;
  logic              owr_q, owr_d;
  logic [11:0]       oaddr_q, oaddr_d;
  logic [12:0]       odata_q, odata_d;
  logic              vld_q;
  logic [12:0]       res [N_OUT];

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign csel     = crd_q ? CSEL_L1 : CSEL_L0;
  assign caddr_rd = addr_q;
  assign waddr    = addr_q[9:0];
  assign owr      = owr_q;
  assign oaddr    = oaddr_q;
  assign odata    = odata_q;

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    fc_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (state_q == S_DONE),
      .load_i   (state_q == S_IDLE),
      .acc_en_i (vld_q),
      .pix_i    (cdata_rd),
      .wgt_i    (wdata[13*j +: 13]),
      .bias_i   (bias[13*j +: 13]),
      .res_o    (res[j])
    );
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    crd_d   = crd_q;
    owr_d   = 1'b0;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;
        busy_d  = 1'b1;
        crd_d   = 1'b1;
        addr_d  = '0;
      end
      S_READ: if (addr_q == LAST_A) begin
        state_d = S_DRAIN;
        crd_d   = 1'b0;
      end else begin
        addr_d = addr_q + 12'd1;
      end
      S_DRAIN: begin
        state_d = S_WRITE;
        wcnt_d  = '0;
      end
      // Results are registered, so each write lands one edge
      // after its WRITE cycle.
      S_WRITE: begin
        owr_d   = 1'b1;
        oaddr_d = 12'(wcnt_q);
        odata_d = res[wcnt_q];
        if (wcnt_q == LAST_K) state_d = S_DONE;
        else wcnt_d = wcnt_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      crd_q   <= 1'b0;
      owr_q   <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      crd_q   <= crd_d;
      owr_q   <= owr_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      // Read data trails its address by one cycle.
      vld_q   <= (state_q == S_READ);
    end
  end
endmodule

// File: tb/tb_fc_layer2.sv
// Directed bench for fc_layer2 with an arithmetic reference model.
// Memories respond with one-cycle latency; outputs sampled on negedge.
module tb_fc_layer2;
  localparam int N_OUT = 4;
  localparam int N_PIX = 1024;
  localparam int LAT   = N_PIX + 2 + N_OUT;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, crd, csel, owr;
  logic [11:0] caddr_rd, oaddr;
  logic [12:0] cdata_rd, odata;
  logic [9:0]  waddr;
  logic [13*N_OUT-1:0] wdata, bias;

  logic [12:0] pix [N_PIX];
  logic [12:0] wt  [N_OUT][N_PIX];
  logic [12:0] bs  [N_OUT];
  logic [12:0] exp_o [N_OUT];
  logic [12:0] got   [N_OUT];

  int checks, errors, n;
  bit mon_on;

  fc_layer2 #(.N_OUT(N_OUT), .N_PIX(N_PIX), .ACC_W(36)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .crd(crd), .csel(csel),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .waddr(waddr), .wdata(wdata), .bias(bias),
    .owr(owr), .oaddr(oaddr), .odata(odata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (crd) begin
      cdata_rd <= pix[caddr_rd[9:0]];
      for (int j = 0; j < N_OUT; j++)
        wdata[13*j +: 13] <= wt[j][waddr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s n=%0d got %0h want %0h", nm, n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", busy, n < LAT);
      chk("done", done, n == LAT);
      chk("crd", crd, n < N_PIX);
      chk("csel", csel, n < N_PIX);
      if (n < N_PIX) begin
        chk("caddr", caddr_rd, n);
        chk("waddr", waddr, n % 1024);
      end
      chk("owr", owr, (n >= N_PIX + 2) && (n < N_PIX + 2 + N_OUT));
      if (n >= N_PIX + 2 && n < N_PIX + 2 + N_OUT) begin
        chk("oaddr", oaddr, n - (N_PIX + 2));
        chk("odata", odata, exp_o[n - (N_PIX + 2)]);
        got[n - (N_PIX + 2)] = odata;
      end
    end
  end

  task automatic setup(input logic [12:0] p, input logic [12:0] w [N_OUT],
                       input logic [12:0] b [N_OUT]);
    for (int i = 0; i < N_PIX; i++) pix[i] = p;
    for (int j = 0; j < N_OUT; j++) begin
      bs[j] = b[j];
      bias[13*j +: 13] = b[j];
      for (int i = 0; i < N_PIX; i++) wt[j][i] = w[j];
    end
  endtask

  // Real-valued sum in units of 1/256, then ReLU, saturate, drop 4 bits.
  task automatic model();
    longint s;
    for (int j = 0; j < N_OUT; j++) begin
      s = longint'($signed(bs[j])) * 16;
      for (int i = 0; i < N_PIX; i++)
        s += longint'(pix[i]) * longint'($signed(wt[j][i]));
      if (s < 0)            exp_o[j] = 13'h0000;
      else if (s >= 131072) exp_o[j] = 13'h1FFF;
      else                  exp_o[j] = 13'(s / 16);
      got[j] = 'x;
    end
  endtask

  task automatic lit(input logic [12:0] e [N_OUT]);
    for (int k = 0; k < N_OUT; k++) begin
      chk("lit_model", exp_o[k], e[k]);
      chk("lit_dut", got[k], e[k]);
    end
  endtask

  task automatic run(input int pulse_at, input int abort_at);
    model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    mon_on = 1'b1;
    #1 start = 1'b0;
    while (n <= LAT) begin
      @(negedge clk);
      start = (n == pulse_at);
      if (n == abort_at) begin
        #2 reset = 1'b1;
        mon_on = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_crd", crd, 0);
        chk("rst_csel", csel, 0);
        chk("rst_owr", owr, 0);
        chk("rst_done", done, 0);
        chk("rst_caddr", caddr_rd, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
          @(negedge clk);
          chk("post_rst_owr", owr, 0);
          chk("post_rst_busy", busy, 0);
        end
        return;
      end
      @(posedge clk);
      n++;
    end
    mon_on = 1'b0;
  endtask

  initial begin
    logic [12:0] w [N_OUT];
    logic [12:0] b [N_OUT];
    logic [12:0] e [N_OUT];
    checks = 0; errors = 0; n = 0; mon_on = 1'b0;
    start = 1'b0; reset = 1'b1; bias = '0; cdata_rd = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_crd", crd, 0);
    chk("r_csel", csel, 0);
    chk("r_owr", owr, 0);
    chk("r_caddr", caddr_rd, 0);
    chk("r_oaddr", oaddr, 0);
    chk("r_odata", odata, 0);
    @(negedge clk) reset = 1'b0;

    w = '{13'h0001, 13'h0001, 13'h0001, 13'h0001};
    b = '{13'h0000, 13'h0000, 13'h0000, 13'h0000};
    setup(13'h0010, w, b);
    run(-1, -1);
    e = '{13'h0400, 13'h0400, 13'h0400, 13'h0400};
    lit(e);

    w = '{13'h0010, 13'h0010, 13'h0010, 13'h0010};
    setup(13'h0010, w, b);
    run(-1, -1);
    e = '{13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF};
    lit(e);

    w = '{13'h0000, 13'h1FFF, 13'h0000, 13'h0000};
    b = '{13'h0000, 13'h0000, 13'h1FF4, 13'h0000};
    setup(13'h0010, w, b);
    run(-1, -1);
    e = '{13'h0000, 13'h0000, 13'h0000, 13'h0000};
    lit(e);

    w = '{13'h0020, 13'h0020, 13'h0020, 13'h0020};
    b = '{13'h0000, 13'h0000, 13'h0000, 13'h0000};
    setup(13'h0000, w, b);
    pix[N_PIX-1] = 13'h0100;
    run(-1, -1);
    e = '{13'h0200, 13'h0200, 13'h0200, 13'h0200};
    lit(e);

    w = '{13'h0001, 13'h0002, 13'h0003, 13'h0004};
    b = '{13'h0000, 13'h0000, 13'h0000, 13'h0010};
    setup(13'h0010, w, b);
    e = '{13'h0400, 13'h0800, 13'h0C00, 13'h1010};
    run(500, -1);
    lit(e);
    run(-1, 700);
    run(-1, -1);
    lit(e);

    for (int i = 0; i < N_PIX; i++) begin
      pix[i] = 13'($urandom_range(0, 255));
      for (int j = 0; j < N_OUT; j++)
        wt[j][i] = 13'($urandom_range(0, 16)) - 13'd8;
    end
    for (int j = 0; j < N_OUT; j++) begin
      bs[j] = 13'($urandom_range(0, 8191));
      bias[13*j +: 13] = bs[j];
    end
    run(-1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
